// File: rtl/alarm_pkg.sv
// Alarm controller shared definitions.
//   - state_e : controller FSM states
//   - field_e : field_sel encodings (which counter the adjust pulses target)
//   - HR_W / MIN_W : hour and minute bus widths
//   - RING_SECS_DEF : default maximum ring duration in tick_1hz periods
//   - helpers to classify states and step through the adjust fields
package alarm_pkg;

  localparam int unsigned HR_W          = 5;
  localparam int unsigned MIN_W         = 6;
  localparam int unsigned RING_CNT_W    = 6;
  localparam int unsigned RING_SECS_DEF = 60;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StAdjChr  = 3'd1,
    StAdjCmin = 3'd2,
    StAdjAhr  = 3'd3,
    StAdjAmin = 3'd4,
    StRing    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FieldClkHr  = 2'd0,
    FieldClkMin = 2'd1,
    FieldAlmHr  = 2'd2,
    FieldAlmMin = 2'd3
  } field_e;

  function automatic logic is_adj(input state_e s);
    return (s == StAdjChr) || (s == StAdjCmin) || (s == StAdjAhr) || (s == StAdjAmin);
  endfunction

  // Field selected by a state; RUN and RING report the clock-hour encoding (0).
  function automatic field_e state_field(input state_e s);
    field_e f;
    case (s)
      StAdjCmin: f = FieldClkMin;
      StAdjAhr:  f = FieldAlmHr;
      StAdjAmin: f = FieldAlmMin;
      default:   f = FieldClkHr;
    endcase
    return f;
  endfunction

  // Next adjust field in the order CHR, CMIN, AHR, AMIN, wrapping to CHR.
  function automatic state_e adj_next(input state_e s);
    state_e n;
    case (s)
      StAdjChr:  n = StAdjCmin;
      StAdjCmin: n = StAdjAhr;
      StAdjAhr:  n = StAdjAmin;
      default:   n = StAdjChr;
    endcase
    return n;
  endfunction

  // Previous adjust field, wrapping CHR back to AMIN.
  function automatic state_e adj_prev(input state_e s);
    state_e p;
    case (s)
      StAdjAmin: p = StAdjAhr;
      StAdjAhr:  p = StAdjCmin;
      StAdjCmin: p = StAdjChr;
      default:   p = StAdjAmin;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
//   clk   : system clock
//   rst   : synchronous active-high reset (clears the history bit)
//   level : debounced button level
//   pulse : high for the single cycle in which level is 1 and was 0 last cycle
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Combinational so the FSM can act on the same edge that records the history.
  assign pulse = level & ~level_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: mode FSM for running, adjusting clock/alarm fields and ringing.
//   clk, rst                 : system clock, synchronous active-high reset
//   tick_1hz                 : one-cycle pulse per second
//   btn_c/l/r/u/d            : debounced levels for mode, field-prev, field-next, up, down
//   alarm_on                 : alarm armed switch
//   cur_hours/cur_mins       : running clock time
//   alm_hours/alm_mins       : alarm time
//   run_en                   : running clock counter enable (paused while adjusting)
//   clk_hr_en .. alm_min_en  : one-cycle adjust pulses to the four counters
//   updown                   : adjust direction (1 up, 0 down), idles at 1
//   field_sel                : field being adjusted (0 outside the adjust states)
//   blink                    : blank strobe for the selected field
//   buzzer                   : alarm sound drive, toggles once per second while ringing
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS = RING_SECS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             btn_c,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             alarm_on,
  input  logic [HR_W-1:0]  cur_hours,
  input  logic [MIN_W-1:0] cur_mins,
  input  logic [HR_W-1:0]  alm_hours,
  input  logic [MIN_W-1:0] alm_mins,
  output logic             run_en,
  output logic             clk_hr_en,
  output logic             clk_min_en,
  output logic             alm_hr_en,
  output logic             alm_min_en,
  output logic             updown,
  output logic [1:0]       field_sel,
  output logic             blink,
  output logic             buzzer
);

  // Count value at which one more tick ends the ring.
  localparam logic [RING_CNT_W-1:0] RingLast = RING_CNT_W'(RING_SECS - 1);

  // Button edge detection
  logic c_e, l_e, r_e, u_e, d_e;

  btn_edge u_edge_c (.clk(clk), .rst(rst), .level(btn_c), .pulse(c_e));
  btn_edge u_edge_l (.clk(clk), .rst(rst), .level(btn_l), .pulse(l_e));
  btn_edge u_edge_r (.clk(clk), .rst(rst), .level(btn_r), .pulse(r_e));
  btn_edge u_edge_u (.clk(clk), .rst(rst), .level(btn_u), .pulse(u_e));
  btn_edge u_edge_d (.clk(clk), .rst(rst), .level(btn_d), .pulse(d_e));

  // Alarm match detection
  logic match_now, match_q, match_evt;

  assign match_now = (cur_hours == alm_hours) && (cur_mins == alm_mins) && alarm_on;
  // match_q follows match_now in every state, so a match already standing when
  // the FSM returns to RUN never looks like a fresh 0->1 transition.
  assign match_evt = match_now & ~match_q;

  // State and next-state decode
  state_e                state_q, state_d;
  logic [RING_CNT_W-1:0] ring_cnt_q;
  logic                  any_btn;
  logic                  ring_done;
  logic                  adj_fire;
  field_e                cur_field;

  always_comb begin
    any_btn   = c_e | l_e | r_e | u_e | d_e;
    ring_done = tick_1hz && (ring_cnt_q == RingLast);
    state_d   = state_q;

    unique case (state_q)
      StRun: begin
        // btn_c wins over a coincident match event; the event is then lost.
        if (c_e) begin
          state_d = StAdjChr;
        end else if (match_evt) begin
          state_d = StRing;
        end
      end
      StAdjChr, StAdjCmin, StAdjAhr, StAdjAmin: begin
        if (c_e) begin
          state_d = StRun;
        end else if (r_e && !l_e) begin
          state_d = adj_next(state_q);
        end else if (l_e && !r_e) begin
          state_d = adj_prev(state_q);
        end
      end
      StRing: begin
        if (any_btn || !alarm_on || ring_done) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // Up/down acts only in a stable adjust state, and only if exactly one of them rose.
    adj_fire  = is_adj(state_q) && (state_d == state_q) && (u_e ^ d_e);
    cur_field = state_field(state_q);
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      match_q    <= 1'b0;
      ring_cnt_q <= '0;
      run_en     <= 1'b1;
      clk_hr_en  <= 1'b0;
      clk_min_en <= 1'b0;
      alm_hr_en  <= 1'b0;
      alm_min_en <= 1'b0;
      updown     <= 1'b1;
      field_sel  <= 2'd0;
      blink      <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_now;

      clk_hr_en  <= adj_fire && (cur_field == FieldClkHr);
      clk_min_en <= adj_fire && (cur_field == FieldClkMin);
      alm_hr_en  <= adj_fire && (cur_field == FieldAlmHr);
      alm_min_en <= adj_fire && (cur_field == FieldAlmMin);
      // Direction follows the pulse it accompanies and otherwise rests at up.
      updown     <= adj_fire ? u_e : 1'b1;

      run_en    <= !is_adj(state_d);
      field_sel <= state_field(state_d);

      if (!is_adj(state_d) || (state_d != state_q)) begin
        blink <= 1'b0;
      end else if (tick_1hz) begin
        blink <= ~blink;
      end

      if (state_d != StRing) begin
        ring_cnt_q <= '0;
        buzzer     <= 1'b0;
      end else if (state_q != StRing) begin
        // First second of the ring sounds.
        ring_cnt_q <= '0;
        buzzer     <= 1'b1;
      end else if (tick_1hz) begin
        ring_cnt_q <= ring_cnt_q + 1'b1;
        buzzer     <= ~buzzer;
      end
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick_1hz;
  logic             btn_c, btn_l, btn_r, btn_u, btn_d;
  logic             alarm_on;
  logic [HR_W-1:0]  cur_hours, alm_hours;
  logic [MIN_W-1:0] cur_mins, alm_mins;
  logic             run_en, clk_hr_en, clk_min_en, alm_hr_en, alm_min_en, updown;
  logic [1:0]       field_sel;
  logic             blink, buzzer;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;

  alarm_ctrl #(.RING_SECS(60)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .alarm_on(alarm_on),
    .cur_hours(cur_hours), .cur_mins(cur_mins),
    .alm_hours(alm_hours), .alm_mins(alm_mins),
    .run_en(run_en),
    .clk_hr_en(clk_hr_en), .clk_min_en(clk_min_en),
    .alm_hr_en(alm_hr_en), .alm_min_en(alm_min_en),
    .updown(updown), .field_sel(field_sel), .blink(blink), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1 ns after the last edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
  endtask

  function automatic logic [3:0] ens();
    return {clk_hr_en, clk_min_en, alm_hr_en, alm_min_en};
  endfunction

  initial begin
    rst = 1'b1; tick_1hz = 1'b0;
    btn_c = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    alarm_on = 1'b0;
    cur_hours = 5'd0; cur_mins = 6'd0; alm_hours = 5'd0; alm_mins = 6'd0;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_state", dut.state_q, StRun);
    chk("rst_run_en", run_en, 1'b1);
    chk("rst_ens", ens(), 4'b0000);
    chk("rst_updown", updown, 1'b1);
    chk("rst_field", field_sel, 2'd0);
    chk("rst_blink", blink, 1'b0);
    chk("rst_buzzer", buzzer, 1'b0);

    // btn_c, btn_r twice, btn_u -> one alarm-hour up pulse
    btn_c = 1'b1; cyc(1);
    chk("c_state", dut.state_q, StAdjChr);
    chk("c_run_en", run_en, 1'b0);
    btn_c = 1'b0; cyc(1);
    btn_r = 1'b1; cyc(1);
    chk("r1_field", field_sel, 2'd1);
    btn_r = 1'b0; cyc(1);
    btn_r = 1'b1; cyc(1);
    chk("r2_state", dut.state_q, StAdjAhr);
    chk("r2_field", field_sel, 2'd2);
    chk("r2_ens", ens(), 4'b0000);
    btn_r = 1'b0; cyc(1);
    btn_u = 1'b1; cyc(1);
    chk("u_ens", ens(), 4'b0010);
    chk("u_updown", updown, 1'b1);
    chk("u_run_en", run_en, 1'b0);
    btn_u = 1'b0; cyc(1);
    chk("u_ens_after", ens(), 4'b0000);

    // Blink toggles on ticks in ADJ, clears back in RUN
    tick();
    chk("blink_t1", blink, 1'b1);
    tick();
    chk("blink_t2", blink, 1'b0);
    tick();
    chk("blink_t3", blink, 1'b1);
    btn_c = 1'b1; cyc(1);
    chk("blink_run", blink, 1'b0);
    chk("back_run_en", run_en, 1'b1);
    btn_c = 1'b0; cyc(1);

    // ADJ_CHR, btn_l wraps to AMIN; held btn_d gives one down pulse
    btn_c = 1'b1; cyc(1);
    btn_c = 1'b0; cyc(1);
    btn_l = 1'b1; cyc(1);
    chk("l_state", dut.state_q, StAdjAmin);
    chk("l_field", field_sel, 2'd3);
    btn_l = 1'b0; cyc(1);
    btn_d = 1'b1; cyc(1);
    chk("d_ens", ens(), 4'b0001);
    chk("d_updown", updown, 1'b0);
    cyc(1);
    chk("d_ens_after", ens(), 4'b0000);
    chk("d_updown_idle", updown, 1'b1);
    pulses = 0;
    for (int i = 0; i < 99; i++) begin
      cyc(1);
      if (ens() != 4'b0000) pulses++;
    end
    chk("d_hold_pulses", pulses, 0);
    btn_d = 1'b0; cyc(1);

    // AMIN -> CHR wrap, then CMIN; simultaneous presses ignored
    btn_r = 1'b1; cyc(1);
    chk("r_wrap_field", field_sel, 2'd0);
    btn_r = 1'b0; cyc(1);
    btn_r = 1'b1; cyc(1);
    chk("cmin_state", dut.state_q, StAdjCmin);
    btn_r = 1'b0; cyc(1);
    btn_u = 1'b1; btn_d = 1'b1; cyc(1);
    chk("ud_ens", ens(), 4'b0000);
    chk("ud_state", dut.state_q, StAdjCmin);
    btn_u = 1'b0; btn_d = 1'b0; cyc(1);
    chk("ud_ens_after", ens(), 4'b0000);
    btn_l = 1'b1; btn_r = 1'b1; cyc(1);
    chk("lr_state", dut.state_q, StAdjCmin);
    chk("lr_field", field_sel, 2'd1);
    btn_l = 1'b0; btn_r = 1'b0; cyc(1);
    btn_c = 1'b1; btn_r = 1'b1; cyc(1);
    chk("cr_prio_state", dut.state_q, StRun);
    btn_c = 1'b0; btn_r = 1'b0; cyc(1);

    // Alarm at 07:30 rings, buzzer alternates, times out after 60 ticks
    alarm_on = 1'b1; alm_hours = 5'd7; alm_mins = 6'd30;
    cur_hours = 5'd7; cur_mins = 6'd29; cyc(1);
    chk("pre_match_state", dut.state_q, StRun);
    cur_mins = 6'd30; cyc(1);
    chk("ring_state", dut.state_q, StRing);
    chk("ring_buz0", buzzer, 1'b1);
    chk("ring_run_en", run_en, 1'b1);
    chk("ring_field", field_sel, 2'd0);
    tick();
    chk("ring_buz1", buzzer, 1'b0);
    tick();
    chk("ring_buz2", buzzer, 1'b1);
    chk("ring_blink", blink, 1'b0);
    for (int i = 3; i <= 59; i++) begin
      tick();
      cyc(1);
    end
    chk("ring59_state", dut.state_q, StRing);
    chk("ring59_buz", buzzer, 1'b0);
    tick();
    chk("ring60_state", dut.state_q, StRun);
    chk("ring60_buz", buzzer, 1'b0);
    cyc(3);
    chk("no_rering", dut.state_q, StRun);

    // Button press stops the ring without an adjust pulse
    cur_mins = 6'd31; cyc(1);
    cur_mins = 6'd30; cyc(1);
    chk("ring2_state", dut.state_q, StRing);
    btn_u = 1'b1; cyc(1);
    chk("ring2_btn_state", dut.state_q, StRun);
    chk("ring2_btn_buz", buzzer, 1'b0);
    chk("ring2_btn_ens", ens(), 4'b0000);
    btn_u = 1'b0; cyc(3);
    chk("ring2_no_rering", dut.state_q, StRun);
    chk("ring2_ens_after", ens(), 4'b0000);

    // Match event coincident with btn_c: btn_c wins, match discarded
    cur_mins = 6'd31; cyc(1);
    cur_mins = 6'd30; btn_c = 1'b1; cyc(1);
    chk("c_vs_match", dut.state_q, StAdjChr);
    btn_c = 1'b0; cyc(1);
    btn_c = 1'b1; cyc(1);
    btn_c = 1'b0; cyc(3);
    chk("c_vs_match_run", dut.state_q, StRun);

    // alarm_on falling ends the ring
    cur_mins = 6'd31; cyc(1);
    cur_mins = 6'd30; cyc(1);
    chk("ring3_state", dut.state_q, StRing);
    alarm_on = 1'b0; cyc(1);
    chk("alarm_off_state", dut.state_q, StRun);
    chk("alarm_off_buz", buzzer, 1'b0);

    // Reset during ring at tick 10
    cur_mins = 6'd31; alarm_on = 1'b1; cyc(1);
    cur_mins = 6'd30; cyc(1);
    chk("ring4_state", dut.state_q, StRing);
    for (int i = 1; i <= 9; i++) begin
      tick();
    end
    chk("ring4_buz9", buzzer, 1'b0);
    rst = 1'b1; tick_1hz = 1'b1; cur_mins = 6'd31; cyc(1);
    tick_1hz = 1'b0;
    chk("rst_ring_state", dut.state_q, StRun);
    chk("rst_ring_buz", buzzer, 1'b0);
    chk("rst_ring_cnt", dut.ring_cnt_q, 0);
    chk("rst_ring_run_en", run_en, 1'b1);
    chk("rst_ring_updown", updown, 1'b1);
    rst = 1'b0; cyc(1);

    // Clock-hour pulse, then reset mid-adjust suppresses a coincident press
    btn_c = 1'b1; cyc(1);
    btn_c = 1'b0; cyc(1);
    btn_u = 1'b1; cyc(1);
    chk("chr_u_ens", ens(), 4'b1000);
    btn_u = 1'b0; cyc(1);
    btn_d = 1'b1; rst = 1'b1; cyc(1);
    chk("rst_adj_ens", ens(), 4'b0000);
    chk("rst_adj_state", dut.state_q, StRun);
    chk("rst_adj_updown", updown, 1'b1);
    chk("rst_adj_run_en", run_en, 1'b1);
    rst = 1'b0; btn_d = 1'b0; cyc(1);
    chk("rst_adj_ens_after", ens(), 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
